// File: rtl/pipeline_pkg.sv
// Shared types and constants for the MIPS pipeline stages.
// Used by the memory-access stage, its bus interface and its M/W register.
package pipeline_pkg;

   localparam int         WORD_W = 32;
   localparam logic [4:0] REG_RA = 5'd31;

   typedef enum logic {
      MEM_IDLE,
      MEM_WAIT
   } mem_state_e;

   typedef struct packed {
      logic reg_write;
      logic mem_to_reg;
   } mem_ctrl_t;

endpackage

// File: rtl/memory_access_if.sv
// Data-memory req/ack bus between the M stage (master) and memory (slave).
interface memory_access_if;
   import pipeline_pkg::*;

   logic              dmem_req;
   logic              dmem_we;
   logic [WORD_W-1:0] dmem_addr;
   logic [WORD_W-1:0] dmem_wdata;
   logic [WORD_W-1:0] dmem_rdata;
   logic              dmem_ack;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  dmem_rdata, dmem_ack
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output dmem_rdata, dmem_ack
   );

endinterface

// File: rtl/writeback_reg.sv
// M/W pipeline register: a bubble clears the control bits and holds the data fields;
// load data is only captured when i_read_en is set.
module writeback_reg
   import pipeline_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              i_bubble,
   input  mem_ctrl_t         i_ctrl,
   input  logic [WORD_W-1:0] i_alu_out,
   input  logic [4:0]        i_write_reg,
   input  logic              i_read_en,
   input  logic [WORD_W-1:0] i_read_data,
   output mem_ctrl_t         o_ctrl,
   output logic [WORD_W-1:0] o_alu_out,
   output logic [4:0]        o_write_reg,
   output logic [WORD_W-1:0] o_read_data
);

   mem_ctrl_t         r_ctrl;
   logic [WORD_W-1:0] r_alu_out;
   logic [4:0]        r_write_reg;
   logic [WORD_W-1:0] r_read_data;

   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_ctrl      <= '0;
         r_alu_out   <= '0;
         r_write_reg <= '0;
         r_read_data <= '0;
      end else if (i_bubble) begin
         r_ctrl <= '0;
      end else begin
         r_ctrl      <= i_ctrl;
         r_alu_out   <= i_alu_out;
         r_write_reg <= i_write_reg;
         if (i_read_en) r_read_data <= i_read_data;
      end
   end

   assign o_ctrl      = r_ctrl;
   assign o_alu_out   = r_alu_out;
   assign o_write_reg = r_write_reg;
   assign o_read_data = r_read_data;

endmodule

// File: rtl/memory_access.sv
// MIPS M stage: drives the data-memory bus, stalls while a transfer is pending, feeds M/W.
// Define MEMORY_ACCESS_TIMEOUT_EN to abort transfers after TIMEOUT_CYCLES wait cycles.
module memory_access
   import pipeline_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              reg_write_m_i,
   input  logic              mem_write_m_i,
   input  logic              mem_to_reg_m_i,
   input  logic [WORD_W-1:0] alu_out_m_i,
   input  logic [WORD_W-1:0] write_data_m_i,
   input  logic [4:0]        write_reg_m_i,
   memory_access_if.master   dmem,
   output logic              stall_m_o,
   output logic              reg_write_w_o,
   output logic              mem_to_reg_w_o,
   output logic [WORD_W-1:0] alu_out_w_o,
   output logic [WORD_W-1:0] read_data_w_o,
   output logic [4:0]        write_reg_w_o,
   output logic              bus_err_o
);

   mem_state_e r_state;
   mem_state_e w_state_nxt;
   logic       w_mem_op;
   logic       w_req;
   logic       w_stall;
   logic       w_abort;
   logic       w_read_en;
   mem_ctrl_t  w_ctrl_m;
   mem_ctrl_t  w_ctrl_w;

   assign w_mem_op = mem_write_m_i | mem_to_reg_m_i;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) r_state <= MEM_IDLE;
      else        r_state <= w_state_nxt;
   end

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_req       = 1'b0;
      w_stall     = 1'b0;
      case (r_state)
         MEM_IDLE: begin
            if (w_mem_op) begin
               w_req = 1'b1;
               if (!dmem.dmem_ack) begin
                  w_stall     = 1'b1;
                  w_state_nxt = MEM_WAIT;
               end
            end
         end
         MEM_WAIT: begin
            w_req = 1'b1;
            if (dmem.dmem_ack) begin
               w_state_nxt = MEM_IDLE;
            end else if (w_abort) begin
               w_req       = 1'b0;
               w_state_nxt = MEM_IDLE;
            end else begin
               w_stall = 1'b1;
            end
         end
         default: w_state_nxt = MEM_IDLE;
      endcase
      // Reset drops the bus request and stall without waiting for a clock edge.
      if (!rst_i) begin
         w_req   = 1'b0;
         w_stall = 1'b0;
      end
   end

`ifdef MEMORY_ACCESS_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] r_wait_cnt;
   logic             r_bus_err;

   assign w_abort = (r_state == MEM_WAIT) && !dmem.dmem_ack &&
                    (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_wait_cnt <= '0;
         r_bus_err  <= 1'b0;
      end else begin
         if (r_state == MEM_WAIT && w_state_nxt == MEM_WAIT) r_wait_cnt <= r_wait_cnt + 1'b1;
         else                                                r_wait_cnt <= '0;
         if (w_abort) r_bus_err <= 1'b1;
      end
   end

   assign bus_err_o = r_bus_err;
`else
   assign w_abort   = 1'b0;
   assign bus_err_o = 1'b0;
`endif

   assign dmem.dmem_req   = w_req;
   assign dmem.dmem_we    = mem_write_m_i;
   assign dmem.dmem_addr  = {alu_out_m_i[WORD_W-1:2], 2'b00};
   assign dmem.dmem_wdata = write_data_m_i;
   assign stall_m_o       = w_stall;

   // A load captures bus data only on the accepting cycle; load+store counts as a store.
   assign w_read_en = w_req & dmem.dmem_ack & mem_to_reg_m_i & ~mem_write_m_i;
   assign w_ctrl_m  = '{reg_write: reg_write_m_i, mem_to_reg: mem_to_reg_m_i};

   writeback_reg u_writeback_reg (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .i_bubble    (w_stall | w_abort),
      .i_ctrl      (w_ctrl_m),
      .i_alu_out   (alu_out_m_i),
      .i_write_reg (write_reg_m_i),
      .i_read_en   (w_read_en),
      .i_read_data (dmem.dmem_rdata),
      .o_ctrl      (w_ctrl_w),
      .o_alu_out   (alu_out_w_o),
      .o_write_reg (write_reg_w_o),
      .o_read_data (read_data_w_o)
   );

   assign reg_write_w_o  = w_ctrl_w.reg_write;
   assign mem_to_reg_w_o = w_ctrl_w.mem_to_reg;

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: directed cases plus random instructions
// checked against a per-instruction behavioural model of the M stage.
module tb_memory_access;
   import pipeline_pkg::*;

   localparam int TO = 4;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        reg_write_m_i, mem_write_m_i, mem_to_reg_m_i;
   logic [31:0] alu_out_m_i, write_data_m_i;
   logic [4:0]  write_reg_m_i;
   logic        stall_m_o, reg_write_w_o, mem_to_reg_w_o, bus_err_o;
   logic [31:0] alu_out_w_o, read_data_w_o;
   logic [4:0]  write_reg_w_o;

   memory_access_if bus ();

   memory_access #(.TIMEOUT_CYCLES(TO)) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .reg_write_m_i  (reg_write_m_i),
      .mem_write_m_i  (mem_write_m_i),
      .mem_to_reg_m_i (mem_to_reg_m_i),
      .alu_out_m_i    (alu_out_m_i),
      .write_data_m_i (write_data_m_i),
      .write_reg_m_i  (write_reg_m_i),
      .dmem           (bus),
      .stall_m_o      (stall_m_o),
      .reg_write_w_o  (reg_write_w_o),
      .mem_to_reg_w_o (mem_to_reg_w_o),
      .alu_out_w_o    (alu_out_w_o),
      .read_data_w_o  (read_data_w_o),
      .write_reg_w_o  (write_reg_w_o),
      .bus_err_o      (bus_err_o)
   );

   always #5 clk_i = ~clk_i;

   int          checks = 0;
   int          errors = 0;
   int          n_xfer, n_stall;
   logic [31:0] exp_alu, exp_rd;
   logic [4:0]  exp_wr;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_w_all(input string tag, input logic rw, input logic m2r);
      check({tag, "_rw"},  {31'd0, reg_write_w_o},  {31'd0, rw});
      check({tag, "_m2r"}, {31'd0, mem_to_reg_w_o}, {31'd0, m2r});
      check({tag, "_alu"}, alu_out_w_o,             exp_alu);
      check({tag, "_wr"},  {27'd0, write_reg_w_o},  {27'd0, exp_wr});
      check({tag, "_rd"},  read_data_w_o,           exp_rd);
   endtask

   // One instruction in M: memory acks after `waits` stalled cycles. Called at posedge+1.
   task automatic do_instr(input logic rw, input logic mw, input logic mr,
                           input logic [31:0] alu, input logic [31:0] wd,
                           input logic [31:0] rd, input logic [4:0] wr, input int waits);
      logic mem_op;
      mem_op         = mw | mr;
      reg_write_m_i  = rw;
      mem_write_m_i  = mw;
      mem_to_reg_m_i = mr;
      alu_out_m_i    = alu;
      write_data_m_i = wd;
      write_reg_m_i  = wr;
      for (int c = 0; c <= waits; c++) begin
         bus.dmem_ack   = mem_op && (c == waits);
         bus.dmem_rdata = (c == waits) ? rd : $urandom;
         @(negedge clk_i);
         check("req",   {31'd0, bus.dmem_req}, {31'd0, mem_op});
         check("stall", {31'd0, stall_m_o},    {31'd0, mem_op && (c < waits)});
         if (mem_op) begin
            check("addr",  bus.dmem_addr,          alu & 32'hFFFF_FFFC);
            check("we",    {31'd0, bus.dmem_we},   {31'd0, mw});
            check("wdata", bus.dmem_wdata,         wd);
         end
         if (bus.dmem_req && bus.dmem_ack) n_xfer++;
         if (stall_m_o) n_stall++;
         @(posedge clk_i);
         #1;
         if (c < waits) begin
            check_w_all("bubble", 1'b0, 1'b0);
         end else begin
            exp_alu = alu;
            exp_wr  = wr;
            if (mr && !mw) exp_rd = rd;
            check_w_all("commit", rw, mr);
         end
      end
      bus.dmem_ack = 1'b0;
   endtask

   initial begin
      rst_i          = 1'b0;
      reg_write_m_i  = 1'b0;
      mem_write_m_i  = 1'b0;
      mem_to_reg_m_i = 1'b0;
      alu_out_m_i    = '0;
      write_data_m_i = '0;
      write_reg_m_i  = '0;
      bus.dmem_ack   = 1'b0;
      bus.dmem_rdata = '0;
      exp_alu = '0; exp_rd = '0; exp_wr = '0;
      n_xfer = 0; n_stall = 0;

      // Reset state
      #12;
      check("rst_req",   {31'd0, bus.dmem_req}, 32'd0);
      check("rst_stall", {31'd0, stall_m_o},    32'd0);
      check("rst_err",   {31'd0, bus_err_o},    32'd0);
      check_w_all("rst", 1'b0, 1'b0);
      @(negedge clk_i) rst_i = 1'b1;
      @(posedge clk_i);
      #1;

      // 1: ALU op
      do_instr(1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'h0, 5'd8, 0);
      // 2: load, zero-wait
      do_instr(1'b1, 1'b0, 1'b1, 32'h0000_0104, 32'h0, 32'hCAFE_F00D, 5'd9, 0);
      // 3: store, 3 waits
      n_stall = 0;
      do_instr(1'b0, 1'b1, 1'b0, 32'h0000_0203, 32'h1234_5678, 32'h0, 5'd0, 3);
      check("t3_stalls", n_stall, 32'd3);
      // 4: back-to-back loads, one wait each
      n_xfer = 0; n_stall = 0;
      do_instr(1'b1, 1'b0, 1'b1, 32'h0000_0400, 32'h0, 32'h1111_2222, 5'd10, 1);
      do_instr(1'b1, 1'b0, 1'b1, 32'h0000_0408, 32'h0, 32'h3333_4444, REG_RA, 1);
      check("t4_xfers",  n_xfer,  32'd2);
      check("t4_stalls", n_stall, 32'd2);
      // Load+store together behaves as a store
      do_instr(1'b1, 1'b1, 1'b1, 32'h0000_0500, 32'hA5A5_5A5A, 32'hDEAD_BEEF, 5'd3, 1);

      // 5: reset in the middle of a waiting load
      reg_write_m_i = 1'b1; mem_write_m_i = 1'b0; mem_to_reg_m_i = 1'b1;
      alu_out_m_i = 32'h0000_0600; write_reg_m_i = 5'd12; bus.dmem_ack = 1'b0;
      @(posedge clk_i);
      #3;
      check("t5_waiting", {31'd0, stall_m_o}, 32'd1);
      rst_i = 1'b0;
      #1;
      check("t5_req",   {31'd0, bus.dmem_req}, 32'd0);
      check("t5_stall", {31'd0, stall_m_o},    32'd0);
      exp_alu = '0; exp_rd = '0; exp_wr = '0;
      check_w_all("t5", 1'b0, 1'b0);
      mem_to_reg_m_i = 1'b0;
      @(negedge clk_i) rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      do_instr(1'b1, 1'b0, 1'b0, 32'h0000_0700, 32'h0, 32'h0, 5'd13, 0);

      // Random instruction mix
      for (int i = 0; i < 40; i++) begin
         int kind;
         int waits;
         kind  = $urandom_range(0, 3);
         waits = (kind == 0) ? 0 : $urandom_range(0, 3);
         do_instr(1'($urandom), kind[1] | (kind == 3), kind[0], $urandom, $urandom, $urandom,
                  5'($urandom), waits);
      end

`ifdef MEMORY_ACCESS_TIMEOUT_EN
      // 6: ack never arrives, abort after TO wait cycles
      reg_write_m_i = 1'b1; mem_write_m_i = 1'b0; mem_to_reg_m_i = 1'b1;
      alu_out_m_i = 32'h0000_0800; write_reg_m_i = 5'd14; bus.dmem_ack = 1'b0;
      for (int c = 0; c <= TO; c++) begin
         @(negedge clk_i);
         check("t6_stall", {31'd0, stall_m_o},    {31'd0, c < TO});
         check("t6_req",   {31'd0, bus.dmem_req}, {31'd0, c < TO});
         @(posedge clk_i);
         #1;
         check_w_all("t6", 1'b0, 1'b0);
      end
      check("t6_err", {31'd0, bus_err_o}, 32'd1);
      do_instr(1'b1, 1'b0, 1'b0, 32'h0000_0900, 32'h0, 32'h0, 5'd15, 0);
      check("t6_sticky", {31'd0, bus_err_o}, 32'd1);
`else
      check("no_err", {31'd0, bus_err_o}, 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
